// File: rtl/sdq_fifo.sv
// sdq_fifo: store-data queue for the LSU store path.
// Circular FIFO of DEPTH entries x WIDTH bits with valid/ready enqueue and
// dequeue, occupancy count, synchronous flush and show-ahead head data.
// DEPTH may be any integer >= 2; pointers wrap explicitly at DEPTH-1.
// Optional feature: define SDQ_FIFO_BYPASS_EN to let an enqueue into an empty
// queue be presented (and consumed) on the dequeue port in the same cycle.
`timescale 1ns/1ps

module sdq_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 17
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         enq_valid,
   output logic                         enq_ready,
   input  logic [WIDTH-1:0]             enq_data,
   output logic                         deq_valid,
   input  logic                         deq_ready,
   output logic [WIDTH-1:0]             deq_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DEPTH);

   // Advance a pointer with an explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Storage is never reset; only pointers and count define which entries are live.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic full_w;
   logic empty_w;
   logic enq_fire;   // producer handshake accepted (and not flushed)
   logic wr_en;      // entry actually written into the array
   logic deq_fire;   // stored head entry consumed

   assign full_w  = (count_q == MAX_CNT);
   assign empty_w = (count_q == '0);

   // Status outputs depend only on registered state.
   assign enq_ready = !full_w;
   assign full      = full_w;
   assign empty     = empty_w;
   assign count     = count_q;

   // Flush wins over any same-cycle handshake, so it gates both fire terms.
   assign enq_fire = enq_valid && !full_w && !flush;
   assign deq_fire = deq_ready && !empty_w && !flush;

`ifdef SDQ_FIFO_BYPASS_EN
   logic byp_fire;   // empty-queue entry handed straight to the consumer

   // An empty queue forwards the incoming entry; if it is taken, it is never stored.
   assign byp_fire  = empty_w && enq_valid && deq_ready && !flush;
   assign wr_en     = enq_fire && !byp_fire;
   assign deq_valid = !empty_w || enq_valid;
   assign deq_data  = empty_w ? enq_data : mem_q[head_q];
`else
   assign wr_en     = enq_fire;
   assign deq_valid = !empty_w;
   assign deq_data  = mem_q[head_q];
`endif

   // Next-state for pointers and occupancy; flush returns everything to the origin.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) begin
            tail_d = ptr_inc(tail_q);
         end
         if (deq_fire) begin
            head_d = ptr_inc(head_q);
         end
         unique case ({wr_en, deq_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry write at the tail; data array carries no reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[tail_q] <= enq_data;
      end
   end

endmodule

// File: tb/tb_sdq_fifo.sv
// Scoreboard bench for sdq_fifo (WIDTH=64, DEPTH=17). Define SDQ_FIFO_BYPASS_EN
// for both bench and design to exercise the bypass build.
`timescale 1ns/1ps

module tb_sdq_fifo;
   localparam int WIDTH = 64;
   localparam int DEPTH = 17;

   logic             clock     = 1'b0;
   logic             reset     = 1'b0;
   logic             flush     = 1'b0;
   logic             enq_valid = 1'b0;
   logic [WIDTH-1:0] enq_data  = '0;
   logic             deq_ready = 1'b0;
   logic             enq_ready;
   logic             deq_valid;
   logic [WIDTH-1:0] deq_data;
   logic [4:0]       count;
   logic             full;
   logic             empty;

   int nvec = 0;
   int nmis = 0;
   int mcount = 0;
   logic [WIDTH-1:0] exp_q[$];

   sdq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Status outputs against the bench's own occupancy model.
   task automatic check_status(input logic ev);
      logic exp_dv;
      exp_dv = (mcount > 0);
`ifdef SDQ_FIFO_BYPASS_EN
      if (mcount == 0 && ev) exp_dv = 1'b1;
`else
      if (ev) exp_dv = exp_dv;
`endif
      chk("count",     64'(count),     64'(mcount));
      chk("full",      64'(full),      64'(mcount == DEPTH));
      chk("empty",     64'(empty),     64'(mcount == 0));
      chk("enq_ready", 64'(enq_ready), 64'(mcount != DEPTH));
      chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
   endtask

   // One clock of stimulus; expected data pushed to the scoreboard when accepted.
   task automatic cycle(input logic ev, input logic [63:0] ed, input logic dr, input logic fl);
      bit acc_enq, acc_deq, byp;
      enq_valid = ev; enq_data = ed; deq_ready = dr; flush = fl;
      @(negedge clock);
      check_status(ev);
      if (fl) begin
         exp_q.delete();
         mcount = 0;
      end else begin
         acc_enq = ev && (mcount < DEPTH);
         acc_deq = dr && (mcount > 0);
         byp = 1'b0;
`ifdef SDQ_FIFO_BYPASS_EN
         if (mcount == 0 && ev && dr) byp = 1'b1;
`endif
         if (acc_enq) exp_q.push_back(ed);
         if (!byp) begin
            if (acc_enq && !acc_deq) mcount++;
            else if (acc_deq && !acc_enq) mcount--;
         end
      end
      @(posedge clock); #1;
      enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
   endtask

   // Monitor: every dequeue handshake must match the scoreboard head.
   initial begin
      forever begin
         @(negedge clock); #1;
         if (!reset && !flush && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
               nvec++; nmis++;
               $display("FAIL deq_unexpected: got %0h, expected no dequeue", deq_data);
            end else begin
               chk("deq_data", deq_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_empty",     64'(empty),     64'd1);
      chk("rst_full",      64'(full),      64'd0);
      chk("rst_enq_ready", 64'(enq_ready), 64'd1);
      chk("rst_deq_valid", 64'(deq_valid), 64'd0);
      reset = 1'b0;
      cycle(0, 0, 0, 0);

      // Fill 0x0..0x10, one extra ignored enqueue, drain, then ignored dequeue.
      for (int i = 0; i < 17; i++) cycle(1, 64'(i), 0, 0);
      cycle(1, 64'h99, 0, 0);
      for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Wrap: move pointers to 10, then push 17 more so both wrap past 16.
      for (int i = 0; i < 10; i++) cycle(1, 64'h50 + 64'(i), 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
      for (int i = 0; i < 17; i++) cycle(1, 64'hA5A5_0000_0000_0000 + 64'(i), 0, 0);
      for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Steady simultaneous enqueue/dequeue at occupancy 5.
      for (int i = 0; i < 5; i++) cycle(1, 64'h100 + 64'(i), 0, 0);
      for (int i = 0; i < 40; i++) cycle(1, 64'h105 + 64'(i), 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Flush at occupancy 9 with both handshakes active.
      for (int i = 0; i < 9; i++) cycle(1, 64'h200 + 64'(i), 0, 0);
      cycle(1, 64'hBAD0_BAD0, 1, 1);
      cycle(0, 0, 1, 0);
      cycle(1, 64'h77, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Asynchronous reset in the middle of a cycle at occupancy 12.
      for (int i = 0; i < 12; i++) cycle(1, 64'h300 + 64'(i), 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("arst_count",     64'(count),     64'd0);
      chk("arst_deq_valid", 64'(deq_valid), 64'd0);
      chk("arst_enq_ready", 64'(enq_ready), 64'd1);
      chk("arst_empty",     64'(empty),     64'd1);
      mcount = 0;
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      cycle(1, 64'h1234, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Empty queue with producer and consumer both active.
      cycle(1, 64'hDEAD_BEEF, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      chk("leftover", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/sdq_fifo.md
# sdq_fifo

Parametrised store-data queue: a circular FIFO of DEPTH entries of WIDTH bits with valid/ready enqueue and dequeue, occupancy count, and synchronous flush. It replaces the fixed 17x64 register-file macro plus external pointer logic in the LSU store-data path, and supports non-power-of-two depths. Head-of-queue data is presented show-ahead on the dequeue port.

## Interface
- WIDTH, 64, data bits per entry (>=1)
- DEPTH, 17, number of entries (>=2, any integer; pointer width = $clog2(DEPTH))
- clock  input  1  sole clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears pointers and count
- flush  input  1  synchronous discard of all entries
- enq_valid  input  1  producer has data
- enq_ready  output  1  queue accepts data (= !full)
- enq_data  input  WIDTH  entry to write
- deq_valid  output  1  head entry available (= !empty)
- deq_ready  input  1  consumer takes head
- deq_data  output  WIDTH  head entry; don't-care while deq_valid=0
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  output  1  count==DEPTH
- empty  output  1  count==0

## Operation
- Storage: DEPTH x WIDTH register array, write on posedge, combinational read at head pointer; array is not reset or cleared.
- Enqueue fires when enq_valid && enq_ready: mem[tail] <= enq_data, tail advances.
- Dequeue fires when deq_valid && deq_ready: head advances.
- Pointer advance: ptr==DEPTH-1 -> 0, else ptr+1 (explicit wrap, not modulo 2^n).
- count: +1 on enq only, -1 on deq only, unchanged on both or neither. Never exceeds DEPTH, never underflows.
- Full: enq_ready=0; simultaneous deq does not enable enq in the same cycle (no full pass-through).
- Empty: deq_valid=0; deq_ready ignored.
- Simultaneous enq and deq when 0<count<DEPTH: both fire, count holds, head and tail both advance (wrap independently).
- flush: next cycle head=tail=0, count=0; flush has priority over any same-cycle enq/deq (enq data discarded, dequeue has no effect). enq_ready/deq_valid during the flush cycle reflect the pre-flush state.
- enq_valid while full or deq_ready while empty: ignored, no state change, no error.

## Timing
- Reset values: count=0, empty=1, full=0, enq_ready=1, deq_valid=0; head=tail=0. Assertion mid-operation discards all entries immediately.
- Enqueue-to-dequeue latency: 1 cycle (entry written at edge N is visible on deq_data with deq_valid=1 after edge N).
- Dequeue: deq_data valid in same cycle as deq_valid; next entry visible after the firing edge.
- enq_ready, deq_valid, full, empty, count are pure functions of registered state; no combinational path from enq_valid/deq_ready to any output.

## Configuration
- SDQ_FIFO_BYPASS_EN defined: when empty and enq_valid=1, deq_valid=1 and deq_data=enq_data combinationally; if deq_ready=1 that cycle, the entry passes through with no write and count stays 0; if deq_ready=0, the entry is written normally. flush still suppresses both enq and bypass dequeue. Introduces combinational paths enq_valid->deq_valid and enq_data->deq_data.
- Not defined: no bypass; 1-cycle minimum latency as above; no input-to-output combinational paths.

## Test plan
- Reset then fill: DEPTH=17, enqueue 0x0..0x10 back-to-back -> count 1..17, full=1 and enq_ready=0 after 17th; 18th enq_valid ignored; drain returns 0x0..0x10 in order, empty=1 after last.
- Wrap: enqueue 10, dequeue 10, then enqueue 0xA5A5_0000_0000_0000+i for i=0..16 -> pointers wrap past 16->0, data returned in order, count peaks at 17.
- Simultaneous enq/deq at count=5 for 40 cycles with incrementing data -> count stays 5, output sequence strictly incrementing, no loss.
- Flush with enq_valid=1, deq_ready=1 at count=9 -> next cycle count=0, empty=1, flushed-cycle enq data never appears on deq_data.
- Async reset asserted mid-cycle at count=12 -> count=0, deq_valid=0, enq_ready=1 before next clock edge; subsequent enq 0x1234 dequeues as 0x1234.
- Bypass (macro on): empty, enq_valid=1, enq_data=0xDEAD_BEEF, deq_ready=1 -> deq_valid=1, deq_data=0xDEAD_BEEF same cycle, count remains 0; macro off -> deq_valid=0 that cycle, data appears next cycle with count=1.
